// File: rtl/trivium_stream.sv
// trivium_stream -- Trivium keystream generator with runtime key/IV loading,
// W-bit-per-clock unrolled generation and a valid/ready output port.
//
// Parameters:
//   W             keystream bits per output word and state steps per clock
//                 (1, 2, 4, 8, 16, 32 or 64)
//   WARMUP_STEPS  initialisation steps discarded before output (multiple of W)
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous reset, active-low
//   enable    global advance enable; when low everything holds (reset excepted)
//   load      single-cycle request: load key/iv and start initialisation
//   key       80-bit key,  key[79-i] = K(i+1)
//   iv        80-bit IV,   iv[79-i]  = IV(i+1)
//   busy      high while the warm-up (INIT) is in progress
//   ks_valid  ks_data holds an unconsumed keystream word
//   ks_ready  downstream accepts the word
//   ks_data   keystream word, bit W-1 is the earliest-generated bit
//
// Handshake: a word transfers on a rising edge where enable && ks_valid &&
// ks_ready (and no load). While ks_valid && !ks_ready the generator state and
// ks_data hold bit-exact, so no keystream bit is ever skipped or repeated.
// A load discards any word that has not been transferred.

module trivium_stream #(
  parameter int W            = 8,
  parameter int WARMUP_STEPS = 1152
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          load,
  input  logic [79:0]   key,
  input  logic [79:0]   iv,
  output logic          busy,
  output logic          ks_valid,
  input  logic          ks_ready,
  output logic [W-1:0]  ks_data
);

  localparam int ADV = WARMUP_STEPS / W;   // warm-up advances (clocks)
  localparam int WCW = $clog2(ADV + 1);

  if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("trivium_stream: W must be one of 1, 2, 4, 8, 16, 32, 64");
  end
  if ((WARMUP_STEPS % W) != 0) begin : g_bad_warmup
    $error("trivium_stream: WARMUP_STEPS must be divisible by W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t         state;
  logic [287:0]   s;        // s[i-1] holds Trivium bit s(i)
  logic [287:0]   s_step;   // state after W chained steps
  logic [287:0]   s_load;   // freshly loaded key/iv image
  logic [W-1:0]   z_step;   // keystream produced by those W steps
  logic [WCW-1:0] wcnt;

  // Load image: s1..s80 = K1..K80, s94..s173 = IV1..IV80, s286..s288 = 1.
  always_comb begin
    s_load = '0;
    for (int i = 0; i < 80; i++) begin
      s_load[i]      = key[79-i];
      s_load[93 + i] = iv[79-i];
    end
    s_load[287:285] = 3'b111;
  end

  // W unrolled Trivium steps; step j feeds z into ks_data bit W-1-j so the
  // earliest bit lands in the MSB.
  always_comb begin
    logic [287:0] cur;
    logic         t1, t2, t3;
    cur    = s;
    z_step = '0;
    for (int j = 0; j < W; j++) begin
      t1 = cur[65]  ^ cur[92];
      t2 = cur[161] ^ cur[176];
      t3 = cur[242] ^ cur[287];
      z_step[W-1-j] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (cur[90]  & cur[91])  ^ cur[170];
      t2 = t2 ^ (cur[174] & cur[175]) ^ cur[263];
      t3 = t3 ^ (cur[285] & cur[286]) ^ cur[68];
      // Each register shifts towards higher index; feedback enters at s1, s94, s178.
      cur = {cur[286:177], t2, cur[175:93], t1, cur[91:0], t3};
    end
    s_step = cur;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      s        <= '0;
      wcnt     <= '0;
      ks_valid <= 1'b0;
      ks_data  <= '0;
    end else if (enable) begin
      if (load) begin
        state    <= INIT;
        s        <= s_load;
        wcnt     <= '0;
        ks_valid <= 1'b0;
        ks_data  <= '0;
      end else begin
        case (state)
          IDLE: ;
          INIT: begin
            s    <= s_step;
            wcnt <= wcnt + WCW'(1);
            if (wcnt == WCW'(ADV - 1)) state <= RUN;
          end
          RUN: begin
            // First edge in RUN fills the empty output; afterwards only a
            // transfer frees the register for the next word.
            if (!ks_valid || ks_ready) begin
              s        <= s_step;
              ks_data  <= z_step;
              ks_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == INIT);

endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream -- directed/randomised bench for trivium_stream.
// Three instances (W=1, 8, 64) share key/iv/load/enable/rst; each has its own
// ks_ready. Expected keystream comes from a bit-serial Trivium model that works
// on a 1-indexed bit array s[1..288].

module tb_trivium_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, load;
  logic [79:0] key, iv;
  logic        rdy1, rdy8, rdy64;
  logic        busy1, busy8, busy64;
  logic        v1, v8, v64;
  logic [0:0]  d1;
  logic [7:0]  d8;
  logic [63:0] d64;

  trivium_stream #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .key(key), .iv(iv),
    .busy(busy1), .ks_valid(v1), .ks_ready(rdy1), .ks_data(d1)
  );
  trivium_stream #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .key(key), .iv(iv),
    .busy(busy8), .ks_valid(v8), .ks_ready(rdy8), .ks_data(d8)
  );
  trivium_stream #(.W(64)) dut64 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .key(key), .iv(iv),
    .busy(busy64), .ks_valid(v64), .ks_ready(rdy64), .ks_data(d64)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  bit         gold_bits[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         got1[$];
  bit         got64[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Bit-serial reference: nbits keystream bits after 1152 discarded steps.
  task automatic gold_gen(input logic [79:0] k, input logic [79:0] v, input int nbits);
    bit s [1:288];
    bit t1, t2, t3, z;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[80-i];
      s[93 + i] = v[80-i];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    gold_bits.delete();
    for (int n = 0; n < 1152 + nbits; n++) begin
      t1 = s[66]  ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91]  & s[92])  ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 178; i--) s[i] = s[i-1];
      s[178] = t2;
      for (int i = 177; i > 94; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 93; i > 1; i--) s[i] = s[i-1];
      s[1] = t3;
      if (n >= 1152) gold_bits.push_back(z);
    end
    exp_q.delete();
    for (int w = 0; w < nbits / 8; w++) begin
      logic [7:0] word;
      for (int b = 0; b < 8; b++) word[7-b] = gold_bits[8*w + b];
      exp_q.push_back(word);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: record transfers that happen at this edge, then verify that a
  // stalled or disabled W=8 output held its word.
  task automatic tick();
    logic       hold;
    logic [7:0] pd;
    if (rst && enable && !load) begin
      if (v8 && rdy8) got_q.push_back(d8);
      if (v1 && rdy1) got1.push_back(d1[0]);
      if (v64 && rdy64) for (int b = 63; b >= 0; b--) got64.push_back(d64[b]);
    end
    hold = rst && !load && v8 && (!enable || !rdy8);
    pd   = d8;
    @(posedge clk);
    #1;
    if (hold) check("hold8", {55'd0, v8, d8}, {55'd0, 1'b1, pd});
  endtask

  task automatic load_dut(input logic [79:0] k, input logic [79:0] v);
    key = k; iv = v; load = 1'b1;
    got_q.delete(); got1.delete(); got64.delete();
    tick();
    load = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!v8 && cycles < 2000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic collect_words(input int n);
    int guard = 0;
    while (got_q.size() < n && guard < 3000) begin
      tick();
      guard++;
    end
  endtask

  task automatic cmp_words(input string tag, input int n);
    check({tag, "_count"}, 64'(got_q.size() >= n), 64'd1);
    for (int i = 0; i < n && got_q.size() > 0 && exp_q.size() > 0; i++)
      check(tag, {56'd0, got_q.pop_front()}, {56'd0, exp_q.pop_front()});
  endtask

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int         cyc, bcnt, first, guard;
    bit         bad;
    logic [79:0] k, v;
    logic [63:0] c_gold, c1, c8, c64;

    rst = 1'b0; enable = 1'b1; load = 1'b1;
    key = '0; iv = '0;
    rdy1 = 1'b1; rdy8 = 1'b1; rdy64 = 1'b1;

    // Reset has priority over load; idle afterwards ignores ks_ready.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", {54'd0, busy8, v8, d8}, 64'd0);
    end
    rst = 1'b1; load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", {54'd0, busy8, v8, d8}, 64'd0);
    end

    // Warm-up timing with all-zero key/iv.
    gold_gen('0, '0, 80);
    load_dut('0, '0);
    bcnt = 0; first = -1; bad = 1'b0;
    for (int e = 0; e <= 200; e++) begin
      if (busy8) bcnt++;
      if (v8 && busy8) bad = 1'b1;
      if (v8) begin
        first = e;
        break;
      end
      tick();
    end
    check("busy_cycles", 64'(bcnt), 64'd144);
    check("first_valid_edge", 64'(first), 64'd145);
    check("valid_in_init", 64'(bad), 64'd0);
    collect_words(10);
    cmp_words("zero_key", 10);

    // Width equivalence: W=1, 8, 64 against the reference, 1024 bits each.
    k = rand80(); v = rand80();
    gold_gen(k, v, 1024);
    load_dut(k, v);
    guard = 0;
    while ((got1.size() < 1024 || got64.size() < 1024 || got_q.size() < 128) && guard < 3000) begin
      tick();
      guard++;
    end
    check("eq_len1", 64'(got1.size() >= 1024), 64'd1);
    check("eq_len64", 64'(got64.size() >= 1024), 64'd1);
    check("eq_len8", 64'(got_q.size() >= 128), 64'd1);
    if (got1.size() >= 1024 && got64.size() >= 1024 && got_q.size() >= 128) begin
      for (int c = 0; c < 16; c++) begin
        for (int b = 0; b < 64; b++) begin
          c_gold[63-b] = gold_bits[64*c + b];
          c1[63-b]     = got1[64*c + b];
          c64[63-b]    = got64[64*c + b];
        end
        for (int w = 0; w < 8; w++) c8[63-8*w -: 8] = got_q[8*c + w];
        check("eq_w1", c1, c_gold);
        check("eq_w8", c8, c_gold);
        check("eq_w64", c64, c_gold);
      end
    end

    // Backpressure: random 30% ready duty while in RUN.
    k = rand80(); v = rand80();
    gold_gen(k, v, 8 * 600);
    load_dut(k, v);
    wait_valid(cyc);
    check("bp_first_valid", 64'(cyc), 64'd145);
    for (int i = 0; i < 500; i++) begin
      rdy8 = ($urandom_range(0, 99) < 30);
      tick();
    end
    rdy8 = 1'b0;
    check("bp_accepted", 64'(got_q.size() >= 50), 64'd1);
    cmp_words("bp", got_q.size());
    rdy8 = 1'b1;

    // Enable stall mid-INIT (after wcnt reaches 70) and mid-RUN.
    k = rand80(); v = rand80();
    gold_gen(k, v, 8 * 40);
    load_dut(k, v);
    repeat (70) tick();
    enable = 1'b0;
    repeat (50) tick();
    check("stall_busy", {63'd0, busy8}, 64'd1);
    enable = 1'b1;
    wait_valid(cyc);
    check("stall_first_valid", 64'(70 + 50 + cyc), 64'd195);
    collect_words(5);
    enable = 1'b0;
    repeat (20) tick();
    enable = 1'b1;
    collect_words(20);
    cmp_words("stall", 20);

    // Reload while a word is pending.
    check("pre_reload_valid", {63'd0, v8}, 64'd1);
    rdy8 = 1'b0;
    k = rand80(); v = rand80();
    gold_gen(k, v, 80);
    load_dut(k, v);
    check("reload_flags", {62'd0, v8, busy8}, 64'd1);
    rdy8 = 1'b1;
    wait_valid(cyc);
    check("reload_first_valid", 64'(cyc), 64'd145);
    collect_words(10);
    cmp_words("reload", 10);

    // Reset mid-INIT returns to IDLE and stays there without a new load.
    load_dut(rand80(), rand80());
    repeat (30) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midinit_reset", {54'd0, busy8, v8, d8}, 64'd0);
    bad = 1'b0;
    repeat (200) begin
      tick();
      if (v8 || busy8) bad = 1'b1;
    end
    check("no_resume", 64'(bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trivium_stream.md
Name: trivium_stream

Overview:
- Parametrised Trivium keystream generator; successor to the fixed 1-bit, free-running `trivium` core.
- Adds runtime key/IV loading and W-bit-per-cycle unrolled generation.
- Exact 4×288-step warm-up sequencing with a busy flag.
- Valid/ready output handshake so downstream cipher datapaths can stall it without losing keystream bits.

Parameters:
- W, 8, keystream bits produced per handshake word and state steps per clock. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value fails elaboration.
- WARMUP_STEPS, 1152, initialisation steps discarded before output. Must be divisible by W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
- enable  input  1  global advance enable; when low, all state, counters and outputs hold.
- load  input  1  single-cycle request to load key/iv and start initialisation.
- key  input  80  secret key; key[79-i] = K(i+1).
- iv  input  80  initialisation vector; iv[79-i] = IV(i+1).
- busy  output  1  high while in INIT.
- ks_valid  output  1  ks_data holds an unconsumed keystream word.
- ks_ready  input  1  downstream accepts the word when ks_valid && ks_ready.
- ks_data  output  W  keystream word; bit W-1 is the earliest-generated bit.

Behaviour:
- FSM states: IDLE, INIT, RUN. Registers: 288-bit state s1..s288, warm-up counter wcnt (ceil log2(WARMUP_STEPS/W + 1) bits), ks_data, ks_valid.
- Reset (rst=0 at an edge) has priority over everything:
  - FSM=IDLE, state all-zero, wcnt=0.
  - ks_valid=0, ks_data=0, busy=0.
- enable=0 freezes everything except reset, including a pending load. load is ignored while enable=0.
- load=1 with enable=1 at an edge, from any state (including mid-INIT or mid-RUN), gives:
  - s1..s93 = K1..K80 followed by 13 zeros.
  - s94..s177 = IV1..IV80 followed by 4 zeros.
  - s178..s285 = 0; s286..s288 = 1.
  - wcnt=0, FSM=INIT, ks_valid=0, ks_data=0.
  - Any unconsumed word is discarded.
- Single Trivium step:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69.
  - Shift: (s1..s93) ← (t3, s1..s92); (s94..s177) ← (t1, s94..s176); (s178..s288) ← (t2, s178..s287).
- Each advance performs W chained steps in one clock. Step j (j = 0..W-1) yields z_j, which maps to ks_data[W-1-j].
- INIT:
  - Each enabled edge advances W steps and increments wcnt; z is discarded.
  - After WARMUP_STEPS/W advances, the FSM moves to RUN with ks_valid=0.
- RUN:
  - On the first enabled edge in RUN, and on every enabled edge where ks_valid && ks_ready, the core advances W steps, ks_data takes the new word, and ks_valid=1.
  - While ks_valid=1 and ks_ready=0, state and ks_data hold bit-exact. No keystream bit is ever skipped or repeated.
- Latency: load accepted at edge E0 → warm-up on edges E1..E(1152/W) → first ks_valid=1 after edge E(1152/W + 1), with enable held high. For W=8: first word after edge E145.
- busy=1 exactly in INIT. ks_valid is never 1 in IDLE or INIT.
- IDLE: holds until load; ks_ready is ignored.
- The keystream sequence is independent of W: concatenating words in order, MSB first, equals the W=1 bit stream.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with load=1, then rst=1 and load=0 for 20 cycles → ks_valid=0, busy=0, ks_data=0 throughout.
- Warm-up timing, W=8: load key=0, iv=0 at E0 with ks_ready=1.
  - busy=1 for exactly 144 cycles.
  - ks_valid first high after E145.
  - 10 words match the bench's bit-serial golden Trivium model, MSB-first.
- Width equivalence: same random key/iv on W=1, W=8, W=64 instances → first 1024 keystream bits identical across all three and equal to the golden model.
- Backpressure: W=8 in RUN, drive ks_ready with a random 30% duty for 500 cycles → ks_data stable while stalled; accepted words concatenate to the golden stream with no gap or duplicate.
- Enable stall: deassert enable for 50 cycles mid-INIT (wcnt=70) and for 20 cycles mid-RUN → first valid is delayed by exactly 50 cycles; output stream is unchanged versus the no-stall run.
- Reload and reset mid-operation:
  - A new load during RUN with ks_valid=1 → ks_valid drops the next cycle and busy=1; the stream restarts per the new key/iv.
  - rst=0 mid-INIT → IDLE; the stream does not resume without a fresh load.
